dcache_responder: RTL

//  Data-cache responder: services the load/store requests that the Memory2 stage issues on its
//  p_addr / p_addr_valid / cache_rw / cache_write -> cache_ready / cache_read interface.

---
 rtl/dcache_responder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with one outstanding request.
// Read misses refill the whole line beat by beat; every store goes through to the memory bus.
module dcache_responder #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p_addr,
  input  logic        p_addr_valid,
  input  logic [1:0]  cache_rw,
  input  logic [31:0] cache_write,
  output logic        cache_ready,
  output logic [31:0] cache_read,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int AW        = INDEX_WIDTH + OFFSET_WIDTH;
  localparam int DEPTH     = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [29:0]             req_addr_q, req_addr_d;
  logic [31:0]             req_wdata_q, req_wdata_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic                    cache_ready_q, cache_ready_d;
  logic [31:0]             cache_read_q, cache_read_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;

  logic [31:0]             data_mem [DEPTH];
  logic [TAG_WIDTH-1:0]    tag_mem  [LINES];

  logic [TAG_WIDTH-1:0]    req_tag_s;
  logic [INDEX_WIDTH-1:0]  req_index_s;
  logic [AW-1:0]           req_slot_s;
  logic                    hit_s;
  logic                    last_beat_s;
  logic                    data_we_s;
  logic [AW-1:0]           data_waddr_s;
  logic [31:0]             data_wdata_s;
  logic                    tag_we_s;
  logic                    unused_addr_bits_s;

  // The word address splits into tag | index | word; byte bits never matter.
  assign req_tag_s          = req_addr_q[29 -: TAG_WIDTH];
  assign req_index_s        = req_addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_slot_s         = req_addr_q[AW-1:0];
  assign hit_s              = valid_q[req_index_s] && (tag_mem[req_index_s] == req_tag_s);
  assign last_beat_s        = (cnt_q == OFFSET_WIDTH'(DEPTH / LINES - 1));
  assign unused_addr_bits_s = ^p_addr[1:0];

  // Next-state, next-output and array write-enable computation for the request FSM.
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    cnt_d         = cnt_q;
    valid_d       = valid_q;
    cache_ready_d = 1'b0;
    cache_read_d  = cache_read_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    data_we_s     = 1'b0;
    data_waddr_s  = req_slot_s;
    data_wdata_s  = req_wdata_q;
    tag_we_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p_addr_valid) begin
          case (cache_rw)
            2'b01: begin
              req_addr_d = p_addr[31:2];
              state_d    = S_LOOKUP;
            end
            2'b10: begin
              req_addr_d  = p_addr[31:2];
              req_wdata_d = cache_write;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = {p_addr[31:2], 2'b00};
              mem_wdata_d = cache_write;
              state_d     = S_WRITE;
            end
            2'b11: begin
              cache_ready_d = 1'b1;
              cache_read_d  = 32'h0000_0000;
              state_d       = S_DONE;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOOKUP: begin
        if (hit_s) begin
          cache_ready_d = 1'b1;
          cache_read_d  = data_mem[req_slot_s];
          state_d       = S_DONE;
        end else begin
          cnt_d      = {OFFSET_WIDTH{1'b0}};
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag_s, req_index_s, {OFFSET_WIDTH{1'b0}}, 2'b00};
          state_d    = S_REFILL;
        end
      end

      // Each beat is followed by one idle cycle before the next request goes out.
      S_REFILL: begin
        if (mem_req_q) begin
          if (mem_ready) begin
            data_we_s    = 1'b1;
            data_waddr_s = {req_index_s, cnt_q};
            data_wdata_s = mem_rdata;
            cnt_d        = cnt_q + OFFSET_WIDTH'(1);
            mem_req_d    = 1'b0;
            if (last_beat_s) begin
              tag_we_s             = 1'b1;
              valid_d[req_index_s] = 1'b1;
              state_d              = S_LOOKUP;
            end else begin
              state_d = S_REFILL;
            end
          end else begin
            state_d = S_REFILL;
          end
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag_s, req_index_s, cnt_q, 2'b00};
        end
      end

      S_WRITE: begin
        if (mem_ready) begin
          mem_req_d     = 1'b0;
          data_we_s     = hit_s;
          cache_ready_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM state, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_addr_q    <= 30'h0000_0000;
      req_wdata_q   <= 32'h0000_0000;
      cnt_q         <= {OFFSET_WIDTH{1'b0}};
      valid_q       <= {LINES{1'b0}};
      cache_ready_q <= 1'b0;
      cache_read_q  <= 32'h0000_0000;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      cache_ready_q <= cache_ready_d;
      cache_read_q  <= cache_read_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (!rst && data_we_s) begin
      data_mem[data_waddr_s] <= data_wdata_s;
    end
    if (!rst && tag_we_s) begin
      tag_mem[req_index_s] <= req_tag_s;
    end
  end

  assign cache_ready = cache_ready_q;
  assign cache_read  = cache_read_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
